bp_cce_ucode_ctrl: RTL and testbench
====================================

Name: bp_cce_ucode_ctrl

Overview:
- Sequencer and arbiter for the CCE microcode RAM programming port (ucode_v/w/addr/data).
- Shares that port between single-word config-bus accesses and a bulk streaming loader.
- After a bulk load, it runs a read-back pass and reports an XOR checksum.
- It drives the RAM port only while the CCE is not in normal mode. The fetch side owns the RAM once the CCE is in normal mode.

Parameters:
- cce_pc_width_p, 8: microcode address width.
- cce_instr_width_p, 48: instruction word width.
- num_cce_instr_ram_els_p, 256: RAM depth. Must be ≤ 2^cce_pc_width_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- mode_normal_i  in  1  CCE is in normal (fetching) mode
- cfg_v_i  in  1  config access valid
- cfg_w_i  in  1  1=write, 0=read
- cfg_addr_i  in  cce_pc_width_p  config address
- cfg_data_i  in  cce_instr_width_p  config write data
- cfg_ready_o  out  1  config access accepted this cycle (valid&ready)
- cfg_data_o  out  cce_instr_width_p  read data
- cfg_data_v_o  out  1  read data valid (one-cycle pulse)
- load_start_i  in  1  start bulk load (pulse)
- load_count_i  in  cce_pc_width_p+1  words to load, sampled on start
- ld_v_i  in  1  stream word valid
- ld_data_i  in  cce_instr_width_p  stream word
- ld_ready_o  out  1  stream word accepted
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse at end of load+verify
- checksum_o  out  cce_instr_width_p  XOR of read-back words; held until next start
- err_o  out  1  one-cycle error pulse
- ucode_v_o, ucode_w_o  out  1 each  RAM port enable, write
- ucode_addr_o  out  cce_pc_width_p  RAM address
- ucode_data_o  out  cce_instr_width_p  RAM write data
- ucode_data_i  in  cce_instr_width_p  RAM read data (1-cycle synchronous)

Behaviour:
- Reset values (async): state=IDLE; every output 0; checksum_r=0; internal counters 0.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE, cfg path:
  - cfg_ready_o = cfg_v_i & ~load_start_i & ~mode_normal_i.
  - An accepted access drives ucode_v_o=1, w=cfg_w_i, addr/data passthrough, in the same cycle (combinational).
  - An accepted read gives cfg_data_v_o=1 the next cycle, with cfg_data_o=ucode_data_i. Back-to-back reads are allowed, one per cycle.
- Arbitration:
  - load_start_i beats cfg_v_i in the same cycle; cfg stalls with ready=0.
  - A cfg read accepted the cycle before a start still returns its data. The data-valid pipeline flop is independent of the FSM.
- IDLE to LOAD: on load_start_i & ~mode_normal_i & 1≤load_count_i≤num_cce_instr_ram_els_p.
  - Latch count, clear wr_ptr, rd_ptr and checksum_r.
  - count==0: go to DONE directly; checksum 0.
  - count>els: err_o=1, stay IDLE.
  - start while mode_normal_i=1: err_o=1, ignored.
- mode_normal_i with cfg_v_i in IDLE: ready=0, no err. The requester waits.
- LOAD:
  - ld_ready_o=1.
  - On ld_v_i: write ld_data_i to addr wr_ptr and increment wr_ptr.
  - After the write where wr_ptr==count-1, go to VERIFY.
  - Gaps in ld_v_i are allowed.
- VERIFY:
  - Issue reads at rd_ptr=0..count-1, one per cycle.
  - A rd_pending flop marks the cycle data returns; then checksum_r ^= ucode_data_i.
  - After the last read is issued, go to DONE. The final data is accumulated in the DONE cycle.
- DONE: done_o=1 for one cycle, with checksum_o final in the same cycle (combinational XOR of the last word). Then go to IDLE.
- mode_normal_i rising in LOAD or VERIFY:
  - Abort to IDLE with err_o=1.
  - Drop ld_ready_o and ucode_v_o in that same cycle.
  - done_o is not asserted.
- The RAM port is never driven while mode_normal_i=1.
- Counters are cce_pc_width_p+1 bits; no wrap occurs because count ≤ els.
- busy_o=1 in LOAD, VERIFY and DONE.

Decomposition:
- Shared package bp_cce_pkg holds:
  - the typedef bp_cce_ucode_ctrl_state_e (IDLE/LOAD/VERIFY/DONE, 2-bit);
  - the verify checksum seed constant (0).
- Sub-module bp_cce_ucode_ctrl_arb holds the combinational IDLE port mux and the cfg read-return flop. The FSM, counters and checksum stay in the top module.

Test Plan:
- Cfg write 0x15←0xA5A5 then cfg read 0x15 → cfg_ready_o=1 both cycles; cfg_data_v_o one cycle after the read; cfg_data_o=0xA5A5.
- load_start count=4; stream 1,2,4,8 with a 2-cycle gap after word 2 → writes to addr 0..3; VERIFY reads 0..3; done_o pulse; checksum_o=0xF; busy_o drops after DONE.
- load_start with cfg_v_i in the same cycle → cfg_ready_o=0; load proceeds; cfg is accepted only after return to IDLE.
- count=0 → done_o on the following cycle; checksum 0. count=els+1 → err_o pulse; state stays IDLE.
- mode_normal_i rises after 2 of 5 words → err_o pulse; ld_ready_o=0 and ucode_v_o=0 the same cycle; IDLE; no done_o.
- Assert reset_i mid-VERIFY (asynchronously, between edges) → all outputs 0 immediately; a subsequent full load completes correctly.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// Shared types and constants for the CCE microcode programming controller.
package bp_cce_pkg;

  typedef enum logic [1:0] {
    e_ucode_idle   = 2'd0,
    e_ucode_load   = 2'd1,
    e_ucode_verify = 2'd2,
    e_ucode_done   = 2'd3
  } bp_cce_ucode_ctrl_state_e;

  localparam logic [63:0] cce_checksum_seed_gp = '0;

endpackage

// File: rtl/bp_cce_ucode_ctrl_arb.sv
// Microcode RAM port mux: config-bus accesses while idle, sequencer requests otherwise,
// plus the config read-return flop (independent of the sequencer state).
module bp_cce_ucode_ctrl_arb
  import bp_cce_pkg::*;
#(
  parameter int cce_pc_width_p    = 8,
  parameter int cce_instr_width_p = 48
)
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  bp_cce_ucode_ctrl_state_e     state,
  input  logic                         mode_normal_i,
  input  logic                         load_start_i,
  input  logic                         cfg_v_i,
  input  logic                         cfg_w_i,
  input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,
  output logic                         cfg_data_v_o,
  input  logic                         fsm_v,
  input  logic                         fsm_w,
  input  logic [cce_pc_width_p-1:0]    fsm_addr,
  input  logic [cce_instr_width_p-1:0] fsm_data,
  input  logic [cce_instr_width_p-1:0] ucode_data_i,
  output logic                         ucode_v_o,
  output logic                         ucode_w_o,
  output logic [cce_pc_width_p-1:0]    ucode_addr_o,
  output logic [cce_instr_width_p-1:0] ucode_data_o
);

  logic cfg_accept;
  logic rd_v_r;

  // A bulk-load start wins over a config access presented in the same cycle.
  assign cfg_accept = ~reset_i & (state == e_ucode_idle) & cfg_v_i
                    & ~load_start_i & ~mode_normal_i;
  assign cfg_ready_o = cfg_accept;

  always_comb begin
    ucode_v_o    = 1'b0;
    ucode_w_o    = 1'b0;
    ucode_addr_o = '0;
    ucode_data_o = '0;
    if (cfg_accept) begin
      ucode_v_o    = 1'b1;
      ucode_w_o    = cfg_w_i;
      ucode_addr_o = cfg_addr_i;
      ucode_data_o = cfg_data_i;
    end else if (fsm_v & ~mode_normal_i) begin
      ucode_v_o    = 1'b1;
      ucode_w_o    = fsm_w;
      ucode_addr_o = fsm_addr;
      ucode_data_o = fsm_data;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_r <= 1'b0;
    end else begin
      rd_v_r <= cfg_accept & ~cfg_w_i;
    end
  end

  assign cfg_data_v_o = rd_v_r;
  assign cfg_data_o   = rd_v_r ? ucode_data_i : '0;

endmodule

// File: rtl/bp_cce_ucode_ctrl.sv
// CCE microcode programming sequencer: config access, bulk stream load, read-back checksum.
//   state  | meaning
//   IDLE   | config accesses allowed, waiting for a load start
//   LOAD   | accepting stream words, writing addr 0..count-1
//   VERIFY | issuing read-backs 0..count-1, folding returns into the checksum
//   DONE   | last read-back folds in, done pulse, back to IDLE
module bp_cce_ucode_ctrl
  import bp_cce_pkg::*;
#(
  parameter int cce_pc_width_p          = 8,
  parameter int cce_instr_width_p       = 48,
  parameter int num_cce_instr_ram_els_p = 256
)
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         mode_normal_i,
  input  logic                         cfg_v_i,
  input  logic                         cfg_w_i,
  input  logic [cce_pc_width_p-1:0]    cfg_addr_i,
  input  logic [cce_instr_width_p-1:0] cfg_data_i,
  output logic                         cfg_ready_o,
  output logic [cce_instr_width_p-1:0] cfg_data_o,
  output logic                         cfg_data_v_o,
  input  logic                         load_start_i,
  input  logic [cce_pc_width_p:0]      load_count_i,
  input  logic                         ld_v_i,
  input  logic [cce_instr_width_p-1:0] ld_data_i,
  output logic                         ld_ready_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [cce_instr_width_p-1:0] checksum_o,
  output logic                         err_o,
  output logic                         ucode_v_o,
  output logic                         ucode_w_o,
  output logic [cce_pc_width_p-1:0]    ucode_addr_o,
  output logic [cce_instr_width_p-1:0] ucode_data_o,
  input  logic [cce_instr_width_p-1:0] ucode_data_i
);

  localparam int cnt_width_lp = cce_pc_width_p + 1;
  localparam logic [cnt_width_lp-1:0] els_lp = cnt_width_lp'(num_cce_instr_ram_els_p);
  localparam logic [cnt_width_lp-1:0] one_lp = cnt_width_lp'(1);

  bp_cce_ucode_ctrl_state_e state_r;
  logic [cnt_width_lp-1:0]      count_r, wr_ptr_r, rd_ptr_r;
  logic [cce_instr_width_p-1:0] checksum_r;
  logic                         rd_pending_r, err_r;

  logic                         start_ok, start_bad, ld_fire, abort;
  logic                         fsm_v, fsm_w;
  logic [cce_pc_width_p-1:0]    fsm_addr;
  logic [cce_instr_width_p-1:0] fsm_data;

  assign start_ok  = load_start_i & ~mode_normal_i & (load_count_i <= els_lp);
  assign start_bad = load_start_i & ~start_ok;
  assign ld_fire   = (state_r == e_ucode_load) & ld_v_i & ~mode_normal_i;
  assign abort     = mode_normal_i & ((state_r == e_ucode_load) | (state_r == e_ucode_verify));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= e_ucode_idle;
      count_r      <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      checksum_r   <= '0;
      rd_pending_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      err_r <= 1'b0;
      unique case (state_r)
        e_ucode_idle: begin
          if (start_ok) begin
            count_r      <= load_count_i;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            checksum_r   <= cce_instr_width_p'(cce_checksum_seed_gp);
            rd_pending_r <= 1'b0;
            state_r      <= (load_count_i == '0) ? e_ucode_done : e_ucode_load;
          end else if (start_bad) begin
            err_r <= 1'b1;
          end
        end
        e_ucode_load: begin
          if (abort) begin
            state_r <= e_ucode_idle;
            err_r   <= 1'b1;
          end else if (ld_v_i) begin
            wr_ptr_r <= wr_ptr_r + one_lp;
            if (wr_ptr_r == count_r - one_lp) state_r <= e_ucode_verify;
          end
        end
        e_ucode_verify: begin
          if (abort) begin
            state_r      <= e_ucode_idle;
            err_r        <= 1'b1;
            rd_pending_r <= 1'b0;
          end else begin
            rd_pending_r <= 1'b1;
            rd_ptr_r     <= rd_ptr_r + one_lp;
            if (rd_pending_r) checksum_r <= checksum_r ^ ucode_data_i;
            if (rd_ptr_r == count_r - one_lp) state_r <= e_ucode_done;
          end
        end
        e_ucode_done: begin
          state_r      <= e_ucode_idle;
          rd_pending_r <= 1'b0;
          if (rd_pending_r) checksum_r <= checksum_r ^ ucode_data_i;
        end
        default: state_r <= e_ucode_idle;
      endcase
    end
  end

  always_comb begin
    fsm_v    = 1'b0;
    fsm_w    = 1'b0;
    fsm_addr = '0;
    fsm_data = '0;
    if (ld_fire) begin
      fsm_v    = 1'b1;
      fsm_w    = 1'b1;
      fsm_addr = wr_ptr_r[cce_pc_width_p-1:0];
      fsm_data = ld_data_i;
    end else if (state_r == e_ucode_verify) begin
      fsm_v    = 1'b1;
      fsm_addr = rd_ptr_r[cce_pc_width_p-1:0];
    end
  end

  bp_cce_ucode_ctrl_arb #(
    .cce_pc_width_p   (cce_pc_width_p),
    .cce_instr_width_p(cce_instr_width_p)
  ) arb (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .state        (state_r),
    .mode_normal_i(mode_normal_i),
    .load_start_i (load_start_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_w_i      (cfg_w_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_data_o   (cfg_data_o),
    .cfg_data_v_o (cfg_data_v_o),
    .fsm_v        (fsm_v),
    .fsm_w        (fsm_w),
    .fsm_addr     (fsm_addr),
    .fsm_data     (fsm_data),
    .ucode_data_i (ucode_data_i),
    .ucode_v_o    (ucode_v_o),
    .ucode_w_o    (ucode_w_o),
    .ucode_addr_o (ucode_addr_o),
    .ucode_data_o (ucode_data_o)
  );

  // The last read-back returns in DONE, so the reported checksum folds it in combinationally.
  assign checksum_o = ((state_r == e_ucode_done) && rd_pending_r) ? (checksum_r ^ ucode_data_i)
                                                                  : checksum_r;
  assign ld_ready_o = (state_r == e_ucode_load) & ~mode_normal_i;
  assign busy_o     = (state_r != e_ucode_idle);
  assign done_o     = (state_r == e_ucode_done);
  assign err_o      = err_r;

endmodule

// File: tb/tb_bp_cce_ucode_ctrl.sv
// Bench for bp_cce_ucode_ctrl: RAM model, transaction-level reference model, directed scenarios.
module tb_bp_cce_ucode_ctrl;

  localparam int PW  = 8;
  localparam int IW  = 48;
  localparam int ELS = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode, cfg_v, cfg_w, load_start, ld_v;
  logic [PW-1:0] cfg_addr;
  logic [IW-1:0] cfg_wdata, ld_data;
  logic [PW:0]   load_count;
  logic          cfg_ready, cfg_data_v, ld_ready, busy, done, err;
  logic [IW-1:0] cfg_rdata, checksum;
  logic          ucode_v, ucode_w;
  logic [PW-1:0] ucode_addr;
  logic [IW-1:0] ucode_wdata, ucode_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_cce_ucode_ctrl #(
    .cce_pc_width_p(PW), .cce_instr_width_p(IW), .num_cce_instr_ram_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_i(rst), .mode_normal_i(mode),
    .cfg_v_i(cfg_v), .cfg_w_i(cfg_w), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_wdata),
    .cfg_ready_o(cfg_ready), .cfg_data_o(cfg_rdata), .cfg_data_v_o(cfg_data_v),
    .load_start_i(load_start), .load_count_i(load_count),
    .ld_v_i(ld_v), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .busy_o(busy), .done_o(done), .checksum_o(checksum), .err_o(err),
    .ucode_v_o(ucode_v), .ucode_w_o(ucode_w), .ucode_addr_o(ucode_addr),
    .ucode_data_o(ucode_wdata), .ucode_data_i(ucode_rdata)
  );

  // Microcode RAM with one-cycle synchronous read
  logic [IW-1:0] ram [ELS];
  logic [IW-1:0] ram_q;
  always @(posedge clk) begin
    if (ucode_v) begin
      if (ucode_w) ram[ucode_addr] <= ucode_wdata;
      else         ram_q <= ram[ucode_addr];
    end
  end
  assign ucode_rdata = ram_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words still to load, reads still to issue, pending pulses
  int            m_load_left, m_verify_left, m_count, m_wr_idx;
  bit            m_done, m_err, m_rd_pend, m_sum_known;
  logic [IW-1:0] m_rd_data, m_sum, m_stream_xor;
  logic [IW-1:0] m_mem [ELS];
  bit            was_idle, was_load, was_ver;

  function automatic bit m_idle();
    return (m_load_left == 0) && (m_verify_left == 0) && !m_done;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load_left = 0; m_verify_left = 0; m_count = 0; m_wr_idx = 0;
      m_done = 0; m_err = 0; m_rd_pend = 0;
      m_sum = '0; m_sum_known = 1; m_stream_xor = '0; m_rd_data = '0;
    end else begin
      was_idle = m_idle();
      was_load = m_load_left > 0;
      was_ver  = m_verify_left > 0;
      m_done = 0; m_err = 0; m_rd_pend = 0;
      if (was_idle) begin
        if (cfg_v && !load_start && !mode) begin
          if (cfg_w) m_mem[cfg_addr] = cfg_wdata;
          else begin m_rd_pend = 1; m_rd_data = m_mem[cfg_addr]; end
        end
        if (load_start) begin
          if (mode || int'(load_count) > ELS) m_err = 1;
          else begin
            m_sum = '0; m_sum_known = 1; m_stream_xor = '0; m_wr_idx = 0;
            m_count = int'(load_count);
            if (m_count == 0) m_done = 1;
            else m_load_left = m_count;
          end
        end
      end else if (was_load) begin
        if (mode) begin m_load_left = 0; m_err = 1; end
        else if (ld_v) begin
          m_mem[m_wr_idx] = ld_data;
          m_stream_xor = m_stream_xor ^ ld_data;
          m_wr_idx++;
          m_load_left--;
          if (m_load_left == 0) m_verify_left = m_count;
        end
      end else if (was_ver) begin
        if (mode) begin m_verify_left = 0; m_err = 1; m_sum_known = 0; end
        else begin
          m_verify_left--;
          if (m_verify_left == 0) begin m_done = 1; m_sum = m_stream_xor; end
        end
      end
    end
  end

  logic          exp_v, exp_w, exp_acc;
  logic [PW-1:0] exp_addr;
  logic [IW-1:0] exp_data;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", 64'({ucode_v, ucode_w, cfg_ready, cfg_data_v, ld_ready, busy, done, err,
                                |ucode_addr, |ucode_wdata, |cfg_rdata, |checksum}), 64'd0);
    end else begin
      if (mode) chk("port_idle_in_normal", 64'(ucode_v), 64'd0);
      exp_acc = m_idle() && cfg_v && !load_start && !mode;
      exp_v = 0; exp_w = 0; exp_addr = '0; exp_data = '0;
      if (exp_acc) begin
        exp_v = 1; exp_w = cfg_w; exp_addr = cfg_addr; exp_data = cfg_wdata;
      end else if (m_load_left > 0 && ld_v && !mode) begin
        exp_v = 1; exp_w = 1; exp_addr = PW'(m_wr_idx); exp_data = ld_data;
      end else if (m_verify_left > 0 && !mode) begin
        exp_v = 1; exp_addr = PW'(m_count - m_verify_left);
      end
      chk("busy", 64'(busy), 64'(!m_idle()));
      chk("done", 64'(done), 64'(m_done));
      chk("err", 64'(err), 64'(m_err));
      chk("ld_ready", 64'(ld_ready), 64'((m_load_left > 0) && !mode));
      chk("cfg_ready", 64'(cfg_ready), 64'(exp_acc));
      chk("cfg_data_v", 64'(cfg_data_v), 64'(m_rd_pend));
      if (m_rd_pend) chk("cfg_data", 64'(cfg_rdata), 64'(m_rd_data));
      chk("ucode_v", 64'(ucode_v), 64'(exp_v));
      if (exp_v) begin
        chk("ucode_w", 64'(ucode_w), 64'(exp_w));
        chk("ucode_addr", 64'(ucode_addr), 64'(exp_addr));
        if (exp_w) chk("ucode_data", 64'(ucode_wdata), 64'(exp_data));
      end
      if (m_done || (m_idle() && m_sum_known)) chk("checksum", 64'(checksum), 64'(m_sum));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stream(input logic [IW-1:0] w);
    tick();
    ld_v = 1'b1;
    ld_data = w;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks %0d", checks);
    $fatal(1, "timeout");
  end

  bit seen;

  initial begin
    for (int i = 0; i < ELS; i++) begin ram[i] = '0; m_mem[i] = '0; end
    ram_q = '0;
    rst = 1'b1; mode = 0; cfg_v = 0; cfg_w = 0; cfg_addr = '0; cfg_wdata = '0;
    load_start = 0; load_count = '0; ld_v = 0; ld_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_busy", 64'(busy), 64'd0);
    chk("lit_reset_checksum", 64'(checksum), 64'd0);

    // config write then read-back
    tick(); cfg_v = 1; cfg_w = 1; cfg_addr = 8'h15; cfg_wdata = 48'hA5A5;
    @(negedge clk);
    chk("lit_cfg_wr_ready", 64'(cfg_ready), 64'd1);
    chk("lit_cfg_wr_port", 64'({ucode_v, ucode_w}), 64'd3);
    tick(); cfg_w = 0;
    @(negedge clk);
    chk("lit_cfg_rd_ready", 64'(cfg_ready), 64'd1);
    tick(); cfg_v = 0;
    @(negedge clk);
    chk("lit_cfg_rd_v", 64'(cfg_data_v), 64'd1);
    chk("lit_cfg_rd_data", 64'(cfg_rdata), 64'hA5A5);

    // four-word load with a two-cycle gap after the second word
    tick(); load_start = 1; load_count = 9'd4;
    tick(); load_start = 0; ld_v = 1; ld_data = 48'h1;
    @(negedge clk);
    chk("lit_ld_ready", 64'(ld_ready), 64'd1);
    stream(48'h2);
    tick(); ld_v = 0;
    tick();
    stream(48'h4);
    stream(48'h8);
    @(negedge clk);
    chk("lit_ld_addr3", 64'(ucode_addr), 64'd3);
    tick(); ld_v = 0;
    @(negedge clk);
    chk("lit_verify_first", 64'({ucode_v, ucode_w, ucode_addr}), 64'({1'b1, 1'b0, 8'd0}));
    wait_done(10, seen);
    chk("lit_done_4", 64'(seen), 64'd1);
    chk("lit_checksum_f", 64'(checksum), 64'hF);
    tick();
    @(negedge clk);
    chk("lit_busy_drop", 64'(busy), 64'd0);

    // start beats a simultaneous config read
    tick(); cfg_v = 1; cfg_w = 0; cfg_addr = 8'h15; load_start = 1; load_count = 9'd2;
    @(negedge clk);
    chk("lit_arb_stall", 64'(cfg_ready), 64'd0);
    tick(); load_start = 0; ld_v = 1; ld_data = 48'h30;
    stream(48'h0C);
    tick(); ld_v = 0;
    wait_done(10, seen);
    chk("lit_done_2", 64'(seen), 64'd1);
    chk("lit_checksum_3c", 64'(checksum), 64'h3C);
    tick();
    @(negedge clk);
    chk("lit_arb_accept_idle", 64'(cfg_ready), 64'd1);
    tick(); cfg_v = 0;
    @(negedge clk);
    chk("lit_arb_rd_data", 64'(cfg_rdata), 64'hA5A5);

    // zero-length load and over-length rejection
    tick(); load_start = 1; load_count = 9'd0;
    tick(); load_start = 0;
    @(negedge clk);
    chk("lit_zero_done", 64'(done), 64'd1);
    chk("lit_zero_sum", 64'(checksum), 64'd0);
    tick(); load_start = 1; load_count = 9'd257;
    tick(); load_start = 0;
    @(negedge clk);
    chk("lit_over_err", 64'(err), 64'd1);
    chk("lit_over_busy", 64'(busy), 64'd0);

    // start and config while in normal mode
    tick(); mode = 1; load_start = 1; load_count = 9'd3; cfg_v = 1;
    @(negedge clk);
    chk("lit_normal_cfg_stall", 64'(cfg_ready), 64'd0);
    tick(); load_start = 0;
    @(negedge clk);
    chk("lit_normal_start_err", 64'({err, busy}), 64'b10);
    tick();
    @(negedge clk);
    chk("lit_normal_cfg_no_err", 64'({err, cfg_ready}), 64'd0);
    tick(); mode = 0; cfg_v = 0;

    // abort after two of five words
    tick(); load_start = 1; load_count = 9'd5;
    tick(); load_start = 0; ld_v = 1; ld_data = 48'h11;
    stream(48'h22);
    tick(); mode = 1; ld_data = 48'h33;
    @(negedge clk);
    chk("lit_abort_same_cycle", 64'({ld_ready, ucode_v, busy}), 64'b001);
    tick(); ld_v = 0;
    @(negedge clk);
    chk("lit_abort_err", 64'({err, busy, done}), 64'b100);
    tick(); mode = 0;

    // asynchronous reset in the middle of VERIFY
    tick(); load_start = 1; load_count = 9'd3;
    tick(); load_start = 0; ld_v = 1; ld_data = 48'h100;
    stream(48'h200);
    stream(48'h400);
    tick(); ld_v = 0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("lit_async_reset", 64'({ucode_v, busy, done, err, ld_ready, |checksum}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // full load after the reset
    tick(); load_start = 1; load_count = 9'd3;
    tick(); load_start = 0; ld_v = 1; ld_data = 48'h7;
    stream(48'h70);
    stream(48'h700);
    tick(); ld_v = 0;
    wait_done(10, seen);
    chk("lit_done_post_reset", 64'(seen), 64'd1);
    chk("lit_checksum_777", 64'(checksum), 64'h777);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
